cont4bits_ctrl: RTL and testbench

CONT4BITS_CTRL -- requirements
Module: cont4bits_ctrl

---
 rtl/cont4bits_pkg.sv | 33 +++
 rtl/cont4bits_core.sv | 31 +++
 rtl/cont4bits_ctrl.sv | 134 +++++++++++++
 tb/tb_cont4bits_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cont4bits_pkg.sv
// Shared definitions for the cont4bits start/stop/pause counter controller:
// default counter width, FSM state encodings, core control strobes and a
// small decode helper for the busy flag.
package cont4bits_pkg;

    // Default counter width in bits.
    localparam int unsigned CNT_W_DEFAULT = 4;

    // Width of the externally visible state encoding.
    localparam int unsigned STATE_W = 2;

    // Controller states; encodings are visible on the state output port.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Per-cycle strobes from the FSM decode to the counter core and the
    // limit capture register.
    typedef struct packed {
        logic clr;   // synchronous clear of the counter
        logic en;    // increment the counter by one
        logic load;  // capture limit into limit_q
    } core_ctrl_t;

    // A run is in progress while counting or frozen by pause.
    function automatic logic is_busy(input state_e s);
        return (s == ST_RUN) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/cont4bits_core.sv
// N-bit counter register used by cont4bits_ctrl.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, forces q to 0
//   clr   - synchronous clear (wins over en)
//   en    - increment q by one on the next rising edge
//   q     - current counter value
module cont4bits_core
    import cont4bits_pkg::*;
#(
    parameter int unsigned N = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] q
);

    // Counter register: clear has priority over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + N'(1);
        end
    end

endmodule

// File: rtl/cont4bits_ctrl.sv
// Start/stop/pause controller for an N-bit up-counter with a programmable
// terminal value and optional auto-reload. A run counts 0..limit_q, one value
// per cycle, and raises done for one cycle after the terminal edge.
// Ports:
//   clk         - rising-edge clock
//   reset       - asynchronous active-high reset
//   start       - begin a run (accepted in IDLE/DONE only)
//   stop        - abort and return to IDLE (highest priority)
//   pause       - level; freezes the count while high
//   auto_reload - 1: restart at 0 after terminal count, 0: one-shot
//   limit       - terminal value, captured on an accepted start
//   count       - current counter value
//   busy        - high in RUN or HOLD
//   done        - one-cycle pulse after the terminal count
//   state       - current FSM state encoding
module cont4bits_ctrl
    import cont4bits_pkg::*;
#(
    parameter int unsigned N = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               auto_reload,
    input  logic [N-1:0]       limit,
    output logic [N-1:0]       count,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    state_e     state_q;
    state_e     state_nxt_c;
    core_ctrl_t ctrl_c;
    logic       done_nxt_c;
    logic       busy_q;
    logic       done_q;
    logic       terminal_c;
    logic [N-1:0] limit_q;
    logic [N-1:0] count_q;

    // Terminal compare against the limit captured at start.
    assign terminal_c = (count_q == limit_q);

    // Next-state and strobe decode; priority is stop > pause > terminal > increment.
    always_comb begin
        state_nxt_c = state_q;
        ctrl_c      = '0;
        done_nxt_c  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    state_nxt_c = ST_IDLE;
                    ctrl_c.clr  = 1'b1;
                end else if (start) begin
                    state_nxt_c = ST_RUN;
                    ctrl_c.clr  = 1'b1;
                    ctrl_c.load = 1'b1;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_nxt_c = ST_IDLE;
                    ctrl_c.clr  = 1'b1;
                end else if (pause) begin
                    // Terminal check is deferred until the run resumes.
                    state_nxt_c = ST_HOLD;
                end else if (terminal_c) begin
                    done_nxt_c = 1'b1;
                    if (auto_reload) begin
                        ctrl_c.clr = 1'b1;
                    end else begin
                        state_nxt_c = ST_DONE;
                    end
                end else begin
                    ctrl_c.en = 1'b1;
                end
            end

            ST_HOLD: begin
                if (stop) begin
                    state_nxt_c = ST_IDLE;
                    ctrl_c.clr  = 1'b1;
                end else if (!pause) begin
                    // Resume without counting on this edge.
                    state_nxt_c = ST_RUN;
                end
            end

            default: begin
                state_nxt_c = ST_IDLE;
                ctrl_c.clr  = 1'b1;
            end
        endcase
    end

    // State, registered flags and limit capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            limit_q <= '0;
        end else begin
            state_q <= state_nxt_c;
            busy_q  <= is_busy(state_nxt_c);
            done_q  <= done_nxt_c;
            if (ctrl_c.load) begin
                limit_q <= limit;
            end
        end
    end

    // Counter datapath.
    cont4bits_core #(
        .N (N)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (ctrl_c.clr),
        .en    (ctrl_c.en),
        .q     (count_q)
    );

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_cont4bits_ctrl.sv
// Directed bench for cont4bits_ctrl: one-shot, auto-reload, pause (including
// pause at the terminal value), start/stop interaction, limit changes during a
// run, asynchronous mid-run reset and the limit=0 / limit=15 edges.
module tb_cont4bits_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       auto_reload;
    logic [3:0] limit;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int vectors;
    int miscompares;

    cont4bits_ctrl #(
        .N (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .limit       (limit),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [1:0] st, input logic [3:0] cnt,
                              input logic bsy, input logic dn);
        cmp({tag, ".state"}, 32'(state), 32'(st));
        cmp({tag, ".count"}, 32'(count), 32'(cnt));
        cmp({tag, ".busy"},  32'(busy),  32'(bsy));
        cmp({tag, ".done"},  32'(done),  32'(dn));
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [1:0] st, input logic [3:0] cnt,
                        input logic bsy, input logic dn);
        tick();
        expect_all(tag, st, cnt, bsy, dn);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        pause       = 1'b0;
        auto_reload = 1'b0;
        limit       = 4'd0;

        // Reset holds everything at zero across clock edges.
        tick();
        tick();
        expect_all("reset", S_IDLE, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step("idle", S_IDLE, 4'd0, 1'b0, 1'b0);

        // One-shot, limit=3.
        limit = 4'd3;
        start = 1'b1;
        step("os0", S_RUN, 4'd0, 1'b1, 1'b0);
        start = 1'b0;
        step("os1", S_RUN, 4'd1, 1'b1, 1'b0);
        step("os2", S_RUN, 4'd2, 1'b1, 1'b0);
        step("os3", S_RUN, 4'd3, 1'b1, 1'b0);
        step("os_done", S_DONE, 4'd3, 1'b0, 1'b1);
        step("os_hold", S_DONE, 4'd3, 1'b0, 1'b0);
        step("os_hold2", S_DONE, 4'd3, 1'b0, 1'b0);

        // Auto-reload, limit=2, restarted from DONE.
        limit       = 4'd2;
        auto_reload = 1'b1;
        start       = 1'b1;
        step("ar0", S_RUN, 4'd0, 1'b1, 1'b0);
        start = 1'b0;
        step("ar1", S_RUN, 4'd1, 1'b1, 1'b0);
        step("ar2", S_RUN, 4'd2, 1'b1, 1'b0);
        step("ar0b", S_RUN, 4'd0, 1'b1, 1'b1);
        step("ar1b", S_RUN, 4'd1, 1'b1, 1'b0);
        step("ar2b", S_RUN, 4'd2, 1'b1, 1'b0);
        step("ar0c", S_RUN, 4'd0, 1'b1, 1'b1);
        stop = 1'b1;
        step("ar_stop", S_IDLE, 4'd0, 1'b0, 1'b0);
        stop        = 1'b0;
        auto_reload = 1'b0;

        // Pause at count=2 for two edges: count shows 2 for three extra cycles.
        limit = 4'd5;
        start = 1'b1;
        step("p0", S_RUN, 4'd0, 1'b1, 1'b0);
        start = 1'b0;
        step("p1", S_RUN, 4'd1, 1'b1, 1'b0);
        step("p2", S_RUN, 4'd2, 1'b1, 1'b0);
        pause = 1'b1;
        step("p_hold_a", S_HOLD, 4'd2, 1'b1, 1'b0);
        step("p_hold_b", S_HOLD, 4'd2, 1'b1, 1'b0);
        pause = 1'b0;
        step("p_resume", S_RUN, 4'd2, 1'b1, 1'b0);
        step("p3", S_RUN, 4'd3, 1'b1, 1'b0);
        step("p4", S_RUN, 4'd4, 1'b1, 1'b0);
        step("p5", S_RUN, 4'd5, 1'b1, 1'b0);
        // Pause at the terminal value defers done.
        pause = 1'b1;
        step("pt_hold", S_HOLD, 4'd5, 1'b1, 1'b0);
        pause = 1'b0;
        step("pt_resume", S_RUN, 4'd5, 1'b1, 1'b0);
        step("pt_done", S_DONE, 4'd5, 1'b0, 1'b1);

        // Start together with stop in DONE resolves to stop.
        start = 1'b1;
        stop  = 1'b1;
        step("ss_done", S_IDLE, 4'd0, 1'b0, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        step("ss_idle", S_IDLE, 4'd0, 1'b0, 1'b0);

        // Start held and limit changed during a run have no effect.
        limit = 4'd2;
        start = 1'b1;
        step("lc0", S_RUN, 4'd0, 1'b1, 1'b0);
        limit = 4'd9;
        step("lc1", S_RUN, 4'd1, 1'b1, 1'b0);
        step("lc2", S_RUN, 4'd2, 1'b1, 1'b0);
        start = 1'b0;
        step("lc_done", S_DONE, 4'd2, 1'b0, 1'b1);

        // Stop while in HOLD.
        limit = 4'd4;
        start = 1'b1;
        step("sh0", S_RUN, 4'd0, 1'b1, 1'b0);
        start = 1'b0;
        step("sh1", S_RUN, 4'd1, 1'b1, 1'b0);
        pause = 1'b1;
        step("sh_hold", S_HOLD, 4'd1, 1'b1, 1'b0);
        stop = 1'b1;
        step("sh_stop", S_IDLE, 4'd0, 1'b0, 1'b0);
        stop  = 1'b0;
        pause = 1'b0;

        // Asynchronous reset at count=7 of a limit=15 run.
        limit = 4'd15;
        start = 1'b1;
        step("mr0", S_RUN, 4'd0, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step("mr_cnt", S_RUN, 4'(i), 1'b1, 1'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        expect_all("mr_async", S_IDLE, 4'd0, 1'b0, 1'b0);
        step("mr_held", S_IDLE, 4'd0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        step("mr_after", S_IDLE, 4'd0, 1'b0, 1'b0);

        // limit=0: DONE on the edge after the accepted start.
        limit = 4'd0;
        start = 1'b1;
        step("l0_run", S_RUN, 4'd0, 1'b1, 1'b0);
        start = 1'b0;
        step("l0_done", S_DONE, 4'd0, 1'b0, 1'b1);
        step("l0_hold", S_DONE, 4'd0, 1'b0, 1'b0);

        // limit=15: all values, no wrap before done.
        limit = 4'd15;
        start = 1'b1;
        step("l15_0", S_RUN, 4'd0, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step("l15_cnt", S_RUN, 4'(i), 1'b1, 1'b0);
        end
        step("l15_done", S_DONE, 4'd15, 1'b0, 1'b1);
        step("l15_hold", S_DONE, 4'd15, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
